// File: rtl/master_arb_pkg.sv
// ----------------------------------------------------------------------------
// master_arb_pkg
//   Shared definitions for the PU master-FIFO link hub.
//   - Derived widths for the default code distances (X=5, Z=4).
//   - Message tag constants (MSB of a master-FIFO word).
//   - addr_to_port: maps a receiver (k, j) pair onto a flat PU port index
//     and flags addresses that do not correspond to a real PU.
// ----------------------------------------------------------------------------
package master_arb_pkg;

    localparam int unsigned CODE_DISTANCE_X_DEFAULT = 5;
    localparam int unsigned CODE_DISTANCE_Z_DEFAULT = 4;

    localparam int unsigned MEASUREMENT_ROUNDS =
        (CODE_DISTANCE_X_DEFAULT > CODE_DISTANCE_Z_DEFAULT) ?
        CODE_DISTANCE_X_DEFAULT : CODE_DISTANCE_Z_DEFAULT;
    localparam int unsigned PER_DIMENSION_WIDTH  = $clog2(MEASUREMENT_ROUNDS);
    localparam int unsigned ADDRESS_WIDTH        = 3 * PER_DIMENSION_WIDTH;
    localparam int unsigned DIRECT_MESSAGE_WIDTH = ADDRESS_WIDTH + 2;
    localparam int unsigned MASTER_FIFO_WIDTH    = DIRECT_MESSAGE_WIDTH + 1;
    localparam int unsigned N_PORTS = MEASUREMENT_ROUNDS * CODE_DISTANCE_Z_DEFAULT;

    localparam logic TAG_NEIGHBOR = 1'b0;
    localparam logic TAG_BLOCKING = 1'b1;

    typedef struct packed {
        logic        invalid;
        logic [15:0] index;
    } port_sel_t;

    // Destination = k*dist_z + j, evaluated at 32 bits so nothing is truncated
    // before the range checks are applied.
    function automatic port_sel_t addr_to_port(
        input int unsigned k,
        input int unsigned j,
        input int unsigned rounds,
        input int unsigned dist_z
    );
        port_sel_t   res;
        int unsigned dest;
        dest        = k * dist_z + j;
        res.invalid = (k >= rounds) || (j >= dist_z) || (dest >= rounds * dist_z);
        res.index   = 16'(dest);
        return res;
    endfunction

endpackage

// File: rtl/master_arbitration_unit_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   N-request round-robin arbiter with an internal priority pointer.
//   Ports:
//     clk, reset   : clock, asynchronous active-high reset (pointer -> 0)
//     req          : request vector
//     advance      : the current grant is being taken; move pointer past it
//     grant        : one-hot grant (valid whenever any_req is high)
//     grant_idx    : binary index of the granted request
//     any_req      : at least one request is present
//   The scan starts at the pointer and wraps; the pointer only moves when a
//   grant is actually taken, so it holds while no request is present.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!any_req && req[cand_idx]) begin
                any_req         = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && any_req) begin
            if (32'(grant_idx) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = IW'(32'(grant_idx) + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/master_arbitration_unit.sv
// ----------------------------------------------------------------------------
// master_arbitration_unit
//   Master-side hub of the PU master-FIFO link. Picks one tagged direct
//   message per cycle from all PU out-FIFOs (round-robin), decodes its
//   receiver address into a destination port and delivers it, tag unchanged,
//   into that port's PU in-FIFO through a single holding register.
//   Also ORs all in-flight indications into has_flying_messages.
//
//   Ports:
//     clk, reset          : clock, asynchronous active-high reset
//     pu_out_data         : N_PORTS x MFW message words, port p at [p*MFW +: MFW]
//     pu_out_valid        : per-port message available
//     pu_out_ready        : one-hot pop of the winning port
//     pu_in_data          : holding-register word, broadcast to all PUs
//     pu_in_valid         : one-hot write strobe to the destination port
//     pu_in_ready         : per-port in-FIFO not full
//     pu_flying           : per-PU in-flight indication
//     has_flying_messages : global in-flight indication
//     drop_error          : sticky, set when an undeliverable address is popped
//     stat_neighbor_cnt   : (MASTER_ARB_STATS_EN) delivered tag-0 messages, saturating
//     stat_blocking_cnt   : (MASTER_ARB_STATS_EN) delivered tag-1 messages, saturating
//
//   Build option: define MASTER_ARB_STATS_EN to add the delivery counters.
// ----------------------------------------------------------------------------
module master_arbitration_unit
    import master_arb_pkg::*;
#(
    parameter  int unsigned CODE_DISTANCE_X = 5,
    parameter  int unsigned CODE_DISTANCE_Z = 4,
    localparam int unsigned MR  = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                  CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int unsigned W   = $clog2(MR),
    localparam int unsigned AW  = 3 * W,
    localparam int unsigned DMW = AW + 2,
    localparam int unsigned MFW = DMW + 1,
    localparam int unsigned NP  = MR * CODE_DISTANCE_Z
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NP*MFW-1:0] pu_out_data,
    input  logic [NP-1:0]     pu_out_valid,
    output logic [NP-1:0]     pu_out_ready,
    output logic [MFW-1:0]    pu_in_data,
    output logic [NP-1:0]     pu_in_valid,
    input  logic [NP-1:0]     pu_in_ready,
    input  logic [NP-1:0]     pu_flying,
`ifdef MASTER_ARB_STATS_EN
    output logic [15:0]       stat_neighbor_cnt,
    output logic [15:0]       stat_blocking_cnt,
`endif
    output logic              has_flying_messages,
    output logic              drop_error
);

    localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;

    logic           hold_valid_q, hold_valid_d;
    logic [MFW-1:0] hold_data_q,  hold_data_d;
    logic [PW-1:0]  hold_dest_q,  hold_dest_d;
    logic           drop_error_q, drop_error_d;

    logic [NP-1:0]  grant;
    logic [PW-1:0]  grant_idx;
    logic           any_req;
    logic           deliver;
    logic           can_accept;
    logic           pop;

    logic [MFW-1:0] win_data;
    logic [W-1:0]   win_k;
    logic [W-1:0]   win_j;
    port_sel_t      win_sel;
    logic           win_drop;

    rr_arbiter #(
        .N (NP)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (pu_out_valid),
        .advance   (pop),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // ------------------------------------------------------------------
    // Delivery side
    // ------------------------------------------------------------------
    always_comb begin
        pu_in_valid = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            pu_in_valid[p] = hold_valid_q && (hold_dest_q == PW'(p));
        end
    end

    assign pu_in_data = hold_data_q;
    assign deliver    = |(pu_in_valid & pu_in_ready);
    assign can_accept = !hold_valid_q || deliver;

    // No pop while reset is asserted: the word would be lost anyway and the
    // upstream FIFOs must see a clean ready=0 during the flush.
    assign pop          = can_accept && any_req && !reset;
    assign pu_out_ready = pop ? grant : '0;

    // ------------------------------------------------------------------
    // Winner decode
    // ------------------------------------------------------------------
    always_comb begin
        win_data = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (grant[p]) begin
                win_data = pu_out_data[p*MFW +: MFW];
            end
        end
    end

    assign win_k   = win_data[DMW-1 -: W];
    assign win_j   = win_data[DMW-1-2*W -: W];
    assign win_sel = addr_to_port(32'(win_k), 32'(win_j), MR, CODE_DISTANCE_Z);

    // A valid destination always fits in PW bits; any upper index bit set
    // can only coincide with an invalid address, so it is folded into the drop.
    assign win_drop = win_sel.invalid || (|(win_sel.index >> PW));

    // ------------------------------------------------------------------
    // Holding register and sticky drop flag
    // ------------------------------------------------------------------
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_dest_d  = hold_dest_q;
        drop_error_d = drop_error_q;
        if (deliver) begin
            hold_valid_d = 1'b0;
        end
        // Refill after drain in the same cycle keeps 1 msg/cycle throughput.
        if (pop) begin
            if (win_drop) begin
                drop_error_d = 1'b1;
            end else begin
                hold_valid_d = 1'b1;
                hold_data_d  = win_data;
                hold_dest_d  = win_sel.index[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_dest_q  <= '0;
            drop_error_q <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_dest_q  <= hold_dest_d;
            drop_error_q <= drop_error_d;
        end
    end

    assign drop_error          = drop_error_q;
    assign has_flying_messages = (|pu_flying) || (|pu_out_valid) || hold_valid_q;

`ifdef MASTER_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-tag delivery counters
    // ------------------------------------------------------------------
    logic [15:0] stat_neighbor_q, stat_neighbor_d;
    logic [15:0] stat_blocking_q, stat_blocking_d;

    always_comb begin
        stat_neighbor_d = stat_neighbor_q;
        stat_blocking_d = stat_blocking_q;
        if (deliver) begin
            if (hold_data_q[MFW-1] == TAG_BLOCKING) begin
                if (stat_blocking_q != 16'hFFFF) begin
                    stat_blocking_d = stat_blocking_q + 16'd1;
                end
            end else begin
                if (stat_neighbor_q != 16'hFFFF) begin
                    stat_neighbor_d = stat_neighbor_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_neighbor_q <= '0;
            stat_blocking_q <= '0;
        end else begin
            stat_neighbor_q <= stat_neighbor_d;
            stat_blocking_q <= stat_blocking_d;
        end
    end

    assign stat_neighbor_cnt = stat_neighbor_q;
    assign stat_blocking_cnt = stat_blocking_q;
`endif

endmodule

// File: tb/tb_master_arbitration_unit.sv
module tb_master_arbitration_unit;

    localparam int NP  = 20;
    localparam int MFW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*MFW-1:0] pu_out_data;
    logic [NP-1:0]     pu_out_valid;
    logic [NP-1:0]     pu_out_ready;
    logic [MFW-1:0]    pu_in_data;
    logic [NP-1:0]     pu_in_valid;
    logic [NP-1:0]     pu_in_ready;
    logic [NP-1:0]     pu_flying;
    logic              has_flying_messages;
    logic              drop_error;
`ifdef MASTER_ARB_STATS_EN
    logic [15:0]       stat_neighbor_cnt;
    logic [15:0]       stat_blocking_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [11:0] rq [NP][$];

    master_arbitration_unit #(
        .CODE_DISTANCE_X (5),
        .CODE_DISTANCE_Z (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .pu_out_data         (pu_out_data),
        .pu_out_valid        (pu_out_valid),
        .pu_out_ready        (pu_out_ready),
        .pu_in_data          (pu_in_data),
        .pu_in_valid         (pu_in_valid),
        .pu_in_ready         (pu_in_ready),
        .pu_flying           (pu_flying),
`ifdef MASTER_ARB_STATS_EN
        .stat_neighbor_cnt   (stat_neighbor_cnt),
        .stat_blocking_cnt   (stat_blocking_cnt),
`endif
        .has_flying_messages (has_flying_messages),
        .drop_error          (drop_error)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input logic tag, input logic [2:0] k,
                                       input logic [2:0] i, input logic [2:0] j,
                                       input logic [1:0] t);
        return {tag, k, i, j, t};
    endfunction

    function automatic logic [19:0] bit20(input int p);
        logic [19:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic set_port(input int p, input logic [11:0] d);
        pu_out_data[p*MFW +: MFW] = d;
    endtask

    // Leaves the caller at a negedge with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        pu_out_valid = '0;
        pu_out_data  = '0;
        pu_in_ready  = '1;
        pu_flying    = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset        = 1'b1;
        pu_out_valid = 20'h00005;
        pu_in_ready  = '1;
        pu_flying    = '0;
        #1;
        total++; if (pu_out_ready !== 20'h0) begin bad++; $display("FAIL reset_out_ready got=%h exp=%h", pu_out_ready, 20'h0); end
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL reset_in_valid got=%h exp=%h", pu_in_valid, 20'h0); end
        total++; if (drop_error !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", drop_error); end
        total++; if (has_flying_messages !== 1'b1) begin bad++; $display("FAIL reset_fly_valid got=%b exp=1", has_flying_messages); end
        pu_out_valid = '0;
        #1;
        total++; if (has_flying_messages !== 1'b0) begin bad++; $display("FAIL reset_fly_idle got=%b exp=0", has_flying_messages); end
        pu_flying = bit20(9);
        #1;
        total++; if (has_flying_messages !== 1'b1) begin bad++; $display("FAIL reset_fly_pu got=%b exp=1", has_flying_messages); end
        @(negedge clk);
        reset     = 1'b0;
        pu_flying = '0;
    endtask

    task automatic test_routing();
        logic [11:0] m;
        m = 12'b0_001_010_011_10;
        do_reset();
        set_port(0, m);
        pu_out_valid = bit20(0);
        #1;
        total++; if (pu_out_ready !== bit20(0)) begin bad++; $display("FAIL route_pop got=%h exp=%h", pu_out_ready, bit20(0)); end
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL route_early got=%h exp=0", pu_in_valid); end
        @(negedge clk);
        pu_out_valid = '0;
        #1;
        total++; if (pu_in_valid !== bit20(7)) begin bad++; $display("FAIL route_dest got=%h exp=%h", pu_in_valid, bit20(7)); end
        total++; if (pu_in_data !== m) begin bad++; $display("FAIL route_data got=%h exp=%h", pu_in_data, m); end
        total++; if (has_flying_messages !== 1'b1) begin bad++; $display("FAIL route_fly_hold got=%b exp=1", has_flying_messages); end
        @(negedge clk);
        #1;
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL route_done got=%h exp=0", pu_in_valid); end
        total++; if (has_flying_messages !== 1'b0) begin bad++; $display("FAIL route_fly_idle got=%b exp=0", has_flying_messages); end
    endtask

    // Self-addressed blocking message: port 7 sends to port 7.
    task automatic test_tag();
        logic [11:0] m;
        m = 12'b1_001_010_011_01;
        do_reset();
        set_port(7, m);
        pu_out_valid = bit20(7);
        #1;
        total++; if (pu_out_ready !== bit20(7)) begin bad++; $display("FAIL tag_pop got=%h exp=%h", pu_out_ready, bit20(7)); end
        @(negedge clk);
        pu_out_valid = '0;
        #1;
        total++; if (pu_in_valid !== bit20(7)) begin bad++; $display("FAIL tag_dest got=%h exp=%h", pu_in_valid, bit20(7)); end
        total++; if (pu_in_data !== m) begin bad++; $display("FAIL tag_data got=%h exp=%h", pu_in_data, m); end
        @(negedge clk);
        #1;
`ifdef MASTER_ARB_STATS_EN
        total++; if (stat_blocking_cnt !== 16'd1) begin bad++; $display("FAIL tag_stat_blk got=%0d exp=1", stat_blocking_cnt); end
        total++; if (stat_neighbor_cnt !== 16'd0) begin bad++; $display("FAIL tag_stat_nb got=%0d exp=0", stat_neighbor_cnt); end
`endif
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL tag_done got=%h exp=0", pu_in_valid); end
    endtask

    task automatic test_fairness();
        int exp_g [7];
        exp_g = '{2, 5, 19, 0, 2, 5, 19};
        do_reset();
        set_port(0,  mk(1'b0, 3'd0, 3'd0, 3'd0, 2'd0));
        set_port(2,  mk(1'b0, 3'd0, 3'd1, 3'd0, 2'd1));
        set_port(5,  mk(1'b1, 3'd0, 3'd2, 3'd0, 2'd2));
        set_port(19, mk(1'b0, 3'd0, 3'd3, 3'd0, 2'd3));
        pu_out_valid = bit20(2) | bit20(5) | bit20(19);
        for (int c = 0; c < 7; c++) begin
            // Port 0 joins right after the first grant to 19: the pointer wrapped.
            if (c == 3) pu_out_valid = pu_out_valid | bit20(0);
            #1;
            total++; if (pu_out_ready !== bit20(exp_g[c])) begin bad++; $display("FAIL fair_grant%0d got=%h exp=%h", c, pu_out_ready, bit20(exp_g[c])); end
            @(negedge clk);
        end
        pu_out_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [11:0] m0, m1;
        m0 = mk(1'b0, 3'd1, 3'd0, 3'd3, 2'b01);
        m1 = mk(1'b1, 3'd1, 3'd1, 3'd3, 2'b10);
        do_reset();
        set_port(0, m0);
        set_port(1, m1);
        pu_out_valid = bit20(0) | bit20(1);
        pu_in_ready  = ~bit20(7);
        #1;
        total++; if (pu_out_ready !== bit20(0)) begin bad++; $display("FAIL bp_first got=%h exp=%h", pu_out_ready, bit20(0)); end
        @(negedge clk);
        pu_out_valid = bit20(1);
        for (int c = 1; c <= 5; c++) begin
            #1;
            total++; if (pu_out_ready !== 20'h0) begin bad++; $display("FAIL bp_stall%0d got=%h exp=0", c, pu_out_ready); end
            total++; if (pu_in_valid !== bit20(7)) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", c, pu_in_valid, bit20(7)); end
            total++; if (pu_in_data !== m0) begin bad++; $display("FAIL bp_data%0d got=%h exp=%h", c, pu_in_data, m0); end
            @(negedge clk);
        end
        pu_in_ready = '1;
        #1;
        total++; if (pu_in_valid !== bit20(7)) begin bad++; $display("FAIL bp_release got=%h exp=%h", pu_in_valid, bit20(7)); end
        total++; if (pu_out_ready !== bit20(1)) begin bad++; $display("FAIL bp_refill got=%h exp=%h", pu_out_ready, bit20(1)); end
        @(negedge clk);
        pu_out_valid = '0;
        #1;
        total++; if (pu_in_valid !== bit20(7)) begin bad++; $display("FAIL bp_second got=%h exp=%h", pu_in_valid, bit20(7)); end
        total++; if (pu_in_data !== m1) begin bad++; $display("FAIL bp_second_data got=%h exp=%h", pu_in_data, m1); end
        @(negedge clk);
        #1;
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL bp_empty got=%h exp=0", pu_in_valid); end
    endtask

    task automatic test_bad_addr();
        logic [11:0] good;
        good = mk(1'b0, 3'd1, 3'd5, 3'd3, 2'd3);
        do_reset();
        set_port(3, mk(1'b0, 3'd7, 3'd0, 3'd1, 2'd0));
        pu_out_valid = bit20(3);
        #1;
        total++; if (pu_out_ready !== bit20(3)) begin bad++; $display("FAIL bad_pop got=%h exp=%h", pu_out_ready, bit20(3)); end
        total++; if (drop_error !== 1'b0) begin bad++; $display("FAIL bad_drop_pre got=%b exp=0", drop_error); end
        @(negedge clk);
        pu_out_valid = '0;
        #1;
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL bad_no_deliver got=%h exp=0", pu_in_valid); end
        total++; if (drop_error !== 1'b1) begin bad++; $display("FAIL bad_drop got=%b exp=1", drop_error); end
        total++; if (has_flying_messages !== 1'b0) begin bad++; $display("FAIL bad_fly got=%b exp=0", has_flying_messages); end
        @(negedge clk);
        set_port(4, mk(1'b1, 3'd0, 3'd0, 3'd4, 2'd0));
        pu_out_valid = bit20(4);
        #1;
        total++; if (pu_out_ready !== bit20(4)) begin bad++; $display("FAIL bad_j_pop got=%h exp=%h", pu_out_ready, bit20(4)); end
        @(negedge clk);
        set_port(1, good);
        pu_out_valid = bit20(1);
        #1;
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL bad_j_drop got=%h exp=0", pu_in_valid); end
        total++; if (pu_out_ready !== bit20(1)) begin bad++; $display("FAIL bad_next_pop got=%h exp=%h", pu_out_ready, bit20(1)); end
        @(negedge clk);
        pu_out_valid = '0;
        #1;
        total++; if (pu_in_valid !== bit20(7)) begin bad++; $display("FAIL bad_then_good got=%h exp=%h", pu_in_valid, bit20(7)); end
        total++; if (drop_error !== 1'b1) begin bad++; $display("FAIL bad_sticky got=%b exp=1", drop_error); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_port(2, mk(1'b0, 3'd6, 3'd0, 3'd0, 2'd0));
        pu_out_valid = bit20(2);
        @(negedge clk);
        set_port(0, mk(1'b1, 3'd1, 3'd0, 3'd3, 2'd1));
        pu_out_valid = bit20(0);
        pu_in_ready  = ~bit20(7);
        @(negedge clk);
        pu_out_valid = '0;
        #1;
        total++; if (pu_in_valid !== bit20(7)) begin bad++; $display("FAIL ar_pre_hold got=%h exp=%h", pu_in_valid, bit20(7)); end
        total++; if (drop_error !== 1'b1) begin bad++; $display("FAIL ar_pre_drop got=%b exp=1", drop_error); end
        total++; if (has_flying_messages !== 1'b1) begin bad++; $display("FAIL ar_pre_fly got=%b exp=1", has_flying_messages); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL ar_in_valid got=%h exp=0", pu_in_valid); end
        total++; if (drop_error !== 1'b0) begin bad++; $display("FAIL ar_drop got=%b exp=0", drop_error); end
        total++; if (has_flying_messages !== 1'b0) begin bad++; $display("FAIL ar_fly got=%b exp=0", has_flying_messages); end
        pu_flying = bit20(11);
        #1;
        total++; if (has_flying_messages !== 1'b1) begin bad++; $display("FAIL ar_fly_pu got=%b exp=1", has_flying_messages); end
        @(negedge clk);
        reset       = 1'b0;
        pu_flying   = '0;
        pu_in_ready = '1;
        #1;
        total++; if (pu_in_valid !== 20'h0) begin bad++; $display("FAIL ar_discarded got=%h exp=0", pu_in_valid); end
    endtask

    // Randomised traffic against a queue-based model of the link.
    task automatic test_random();
        int          m_ptr, m_dest, win, r, n_nb, n_bl;
        logic        m_v, m_drop, dlv, acc;
        logic [11:0] m_data, msg;
        logic [2:0]  k, j;
        logic [19:0] e_ready, e_inv;
        do_reset();
        for (int p = 0; p < NP; p++) rq[p].delete();
        m_ptr = 0; m_dest = 0; m_v = 1'b0; m_drop = 1'b0; m_data = '0;
        n_nb = 0; n_bl = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 99) < 15) begin
                    k = 3'($urandom_range(0, 4));
                    j = 3'($urandom_range(0, 3));
                    r = int'($urandom_range(0, 19));
                    if (r == 0) k = 3'($urandom_range(5, 7));
                    else if (r == 1) j = 3'($urandom_range(4, 7));
                    rq[p].push_back(mk(1'($urandom), k, 3'($urandom), j, 2'($urandom)));
                end
            end
            pu_in_ready = 20'($urandom | $urandom);
            pu_flying   = ($urandom_range(0, 3) == 0) ? bit20(int'($urandom_range(0, 19))) : '0;
            for (int p = 0; p < NP; p++) begin
                pu_out_valid[p] = (rq[p].size() > 0);
                pu_out_data[p*MFW +: MFW] = (rq[p].size() > 0) ? rq[p][0] : 12'h000;
            end
            #1;
            e_inv = '0;
            if (m_v) e_inv[m_dest] = 1'b1;
            dlv = m_v && pu_in_ready[m_dest];
            acc = !m_v || dlv;
            win = -1;
            if (acc) begin
                for (int o = 0; o < NP; o++) begin
                    int p;
                    p = (m_ptr + o) % NP;
                    if (win < 0 && rq[p].size() > 0) win = p;
                end
            end
            e_ready = '0;
            if (win >= 0) e_ready[win] = 1'b1;
            total++; if (pu_out_ready !== e_ready) begin bad++; $display("FAIL rnd_out_ready c=%0d got=%h exp=%h", c, pu_out_ready, e_ready); end
            total++; if (pu_in_valid !== e_inv) begin bad++; $display("FAIL rnd_in_valid c=%0d got=%h exp=%h", c, pu_in_valid, e_inv); end
            if (m_v) begin
                total++; if (pu_in_data !== m_data) begin bad++; $display("FAIL rnd_in_data c=%0d got=%h exp=%h", c, pu_in_data, m_data); end
            end
            total++; if (drop_error !== m_drop) begin bad++; $display("FAIL rnd_drop c=%0d got=%b exp=%b", c, drop_error, m_drop); end
            total++; if (has_flying_messages !== ((|pu_flying) || (|pu_out_valid) || m_v)) begin
                bad++; $display("FAIL rnd_fly c=%0d got=%b", c, has_flying_messages);
            end
            if (dlv) begin
                if (m_data[11]) n_bl++; else n_nb++;
                m_v = 1'b0;
            end
            if (win >= 0) begin
                msg   = rq[win].pop_front();
                m_ptr = (win + 1) % NP;
                k     = msg[10:8];
                j     = msg[4:2];
                if (k < 3'd5 && j < 3'd4) begin
                    m_v    = 1'b1;
                    m_data = msg;
                    m_dest = int'(k) * 4 + int'(j);
                end else begin
                    m_drop = 1'b1;
                end
            end
            @(negedge clk);
        end
        pu_out_valid = '0;
        #1;
`ifdef MASTER_ARB_STATS_EN
        total++; if (stat_neighbor_cnt !== 16'(n_nb)) begin bad++; $display("FAIL rnd_stat_nb got=%0d exp=%0d", stat_neighbor_cnt, n_nb); end
        total++; if (stat_blocking_cnt !== 16'(n_bl)) begin bad++; $display("FAIL rnd_stat_blk got=%0d exp=%0d", stat_blocking_cnt, n_bl); end
`endif
        total++; if (n_nb + n_bl == 0) begin bad++; $display("FAIL rnd_no_traffic got=0 exp=nonzero"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        pu_out_data  = '0;
        pu_out_valid = '0;
        pu_in_ready  = '1;
        pu_flying    = '0;
        test_reset();
        test_routing();
        test_tag();
        test_fairness();
        test_backpressure();
        test_bad_addr();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/master_arbitration_unit.md
# master_arbitration_unit

Master-side endpoint of the PU master-FIFO link, one shared hub for all PU arbitration units. Collects tagged direct messages from every PU out-FIFO and picks one per cycle, round-robin. Decodes the receiver address into a destination port and delivers the message, tag bit unchanged, into that port's PU in-FIFO. Also aggregates per-port in-flight indications into the global `has_flying_messages` used by the decoder's termination logic.

## Interface
- `CODE_DISTANCE_X`, default 5: code distance X.
- `CODE_DISTANCE_Z`, default 4: code distance Z.
- Derived, not overridable:
  - `MEASUREMENT_ROUNDS = max(X,Z)`
  - `PER_DIMENSION_WIDTH = $clog2(MEASUREMENT_ROUNDS)` (W)
  - `ADDRESS_WIDTH = 3W`
  - `DIRECT_MESSAGE_WIDTH = ADDRESS_WIDTH+2`
  - `MASTER_FIFO_WIDTH = DIRECT_MESSAGE_WIDTH+1` (MSB = tag: 0 neighbor, 1 blocking)
  - `N_PORTS = MEASUREMENT_ROUNDS*CODE_DISTANCE_Z`
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high reset.
- `pu_out_data` input N_PORTS*MASTER_FIFO_WIDTH: port p occupies slice [p*MFW +: MFW]. Source is each PU's `master_fifo_out_data`.
- `pu_out_valid` input N_PORTS: per-port message available.
- `pu_out_ready` output N_PORTS: one-hot pop of the winning port.
- `pu_in_data` output MASTER_FIFO_WIDTH: broadcast to every PU's `master_fifo_in_data`.
- `pu_in_valid` output N_PORTS: one-hot write strobe to the destination port.
- `pu_in_ready` input N_PORTS: per-port in-FIFO not full.
- `pu_flying` input N_PORTS: per-PU `has_flying_messages`.
- `has_flying_messages` output 1: global in-flight indication.
- `drop_error` output 1: sticky; set on an undeliverable address.

## Operation
- Address layout, receiver field = `data[DIRECT_MESSAGE_WIDTH-1 -: ADDRESS_WIDTH]`:
  - k = top W bits
  - i = middle W bits
  - j = low W bits
  - destination = k*CODE_DISTANCE_Z + j, computed at width $clog2(N_PORTS)+1 with no truncation.
- Two-stage path: arbitration stage, then a single holding register (`hold_valid`, `hold_data`, `hold_dest`).
- Holding register can accept when `!hold_valid || (pu_in_valid[hold_dest] && pu_in_ready[hold_dest])`. Drain and refill may happen in the same cycle.
- Arbitration, only when the holding register can accept:
  - Scan `pu_out_valid` from `rr_ptr` upward with wrap; first hit wins.
  - Assert `pu_out_ready[win]` for that cycle only.
  - Load the holding register.
  - `rr_ptr <= (win+1) mod N_PORTS`.
  - `rr_ptr` holds its value when no port is valid.
- Invalid destination (k ≥ MEASUREMENT_ROUNDS, j ≥ CODE_DISTANCE_Z, or destination ≥ N_PORTS):
  - Message is still popped, but not loaded.
  - `drop_error` is set to 1 and stays set until reset.
- `pu_in_valid = hold_valid ? (1 << hold_dest) : 0`; `pu_in_data = hold_data`.
- Tag bit and payload pass through bit-exact.
- `has_flying_messages = |pu_flying || |pu_out_valid || hold_valid`.
- Self-addressed messages (destination == source) are legal and delivered normally.

## Timing
- Reset values:
  - `hold_valid=0`, `hold_data=0`, `rr_ptr=0`, `drop_error=0`
  - all `pu_out_ready`, `pu_in_valid` = 0
  - `has_flying_messages` follows its inputs combinationally.
- Latency: pop in cycle T, then `pu_in_valid` in cycle T+1.
- Throughput: 1 message/cycle while destinations are ready.
- Holding register blocked (destination not ready):
  - No pop occurs; `pu_out_ready` = 0.
  - Data is held stable.
  - `pu_in_valid` stays asserted until accepted.
- Reset asserted mid-transfer: the held message is discarded and the upstream FIFO has already been popped. Loss is accepted; reset is a global flush.
- `pu_out_ready` depends combinationally on `pu_in_ready`, with no combinational path from `pu_out_data`.

## Configuration
- `MASTER_ARB_STATS_EN` defined:
  - Adds two 16-bit saturating counters, `stat_neighbor_cnt` (tag 0) and `stat_blocking_cnt` (tag 1).
  - Both increment on delivery handshake, saturate at 16'hFFFF and reset to 0.
  - Both are exposed as output ports.
- Macro undefined: counters and ports are absent; behaviour is otherwise identical.

## Structure
- The shared package `master_arb_pkg` holds:
  - derived localparams (W, ADDRESS_WIDTH, DIRECT_MESSAGE_WIDTH, MASTER_FIFO_WIDTH, N_PORTS)
  - tag constants `TAG_NEIGHBOR=1'b0`, `TAG_BLOCKING=1'b1`
  - function `addr_to_port` returning {invalid, index}.
- One sub-module, `rr_arbiter` (N-request round-robin with pointer, one-hot grant). Everything else is inline.

## Test plan
All cases use defaults: W=3, MFW=12, N_PORTS=20.
- Routing: port 0 sends 12'b0_001_010_011_10 (k=1, i=2, j=3), all ready.
  - Cycle 0: `pu_out_ready[0]`.
  - Cycle 1: `pu_in_valid[7]` only, data identical.
- Tag preserved: the same address with MSB=1 arrives at port 7 with MSB=1; with STATS, `stat_blocking_cnt`=1 and `stat_neighbor_cnt`=0.
- Fairness: ports 2, 5 and 19 continuously valid, all destinations ready.
  - Grant order is 2, 5, 19, 2, 5, 19.
  - After the first 19 grant, `rr_ptr` wraps to 0.
- Backpressure: `pu_in_ready[7]=0` for 5 cycles with ports 0 and 1 both targeting port 7.
  - Exactly one pop, `pu_in_valid[7]` held 5 cycles.
  - On release, the delivery and the next pop occur in the same cycle.
- Bad address k=7:
  - Message popped, no `pu_in_valid`, `drop_error`=1.
  - `drop_error` stays 1 through further traffic until reset.
- Async reset asserted mid-cycle with `hold_valid`=1:
  - `pu_in_valid`=0 immediately, `drop_error`=0.
  - `has_flying_messages` follows `pu_flying` only.
